acc_round_scheduler: RTL and testbench

ACC_ROUND_SCHEDULER -- requirements
Module: acc_round_scheduler

---
 rtl/acc_pkg.sv | 28 ++
 rtl/acc_wait_counter.sv | 37 +++
 rtl/acc_round_scheduler.sv | 189 ++++++++++++++++++
 tb/tb_acc_round_scheduler.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/acc_pkg.sv
// Shared types and defaults for the accumulator round scheduler.
package acc_pkg;

  // Scheduler states; one round walks StKey -> StIntt -> StDecomp -> StNtt -> StNext.
  typedef enum logic [2:0] {
    StIdle,
    StKey,
    StIntt,
    StDecomp,
    StNtt,
    StNext,
    StFin
  } acc_state_e;

  localparam int unsigned DecompWaitDefault = 9;
  localparam int unsigned TimeoutDefault    = 65535;

  // Number of bits needed to hold max_val (at least 1).
  function automatic int unsigned cnt_width(input int unsigned max_val);
    int unsigned w;
    w = 1;
    while ((max_val >> w) != 0) begin
      w++;
    end
    return w;
  endfunction

endpackage

// File: rtl/acc_wait_counter.sv
// Loadable down-counter shared by the decompose delay and the watchdog.
// tc is high while the count is zero; the count holds at zero.
module acc_wait_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             enable,
  output logic             tc
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  // Load has priority over counting.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (enable && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == '0);

endmodule

// File: rtl/acc_round_scheduler.sv
// Round scheduler for key-switch accumulation: per round fetch a key, run
// INTT, wait for decompose, run NTT. Optional watchdog on the KEY/INTT/NTT
// waits is enabled by defining ACC_ROUND_TIMEOUT_EN.
module acc_round_scheduler
  import acc_pkg::*;
#(
  parameter int unsigned ROUND_W     = 10,
  parameter int unsigned DECOMP_WAIT = DecompWaitDefault,
  parameter int unsigned TIMEOUT_CYC = TimeoutDefault
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [ROUND_W-1:0] n_rounds,
  output logic               key_req,
  input  logic               key_ack,
  output logic [ROUND_W-1:0] key_idx,
  output logic               intt_start,
  input  logic               intt_done,
  output logic               ntt_start,
  input  logic               ntt_done,
  output logic               busy,
  output logic               done_acc,
  output logic               done,
  output logic [ROUND_W-1:0] round_cnt,
  output logic               timeout_err
);

`ifdef ACC_ROUND_TIMEOUT_EN
  localparam int unsigned MaxLoad = (TIMEOUT_CYC > DECOMP_WAIT) ? TIMEOUT_CYC : DECOMP_WAIT;
`else
  localparam int unsigned MaxLoad = DECOMP_WAIT;
`endif
  localparam int unsigned CntW = cnt_width(MaxLoad);

  if (DECOMP_WAIT < 1 || DECOMP_WAIT > 255 || TIMEOUT_CYC < 1) begin : g_bad_param
    $error("acc_round_scheduler: DECOMP_WAIT must be 1..255 and TIMEOUT_CYC nonzero");
  end

  acc_state_e         state_q, state_d;
  logic [ROUND_W-1:0] n_lat_q, n_lat_d;
  logic [ROUND_W-1:0] round_cnt_q, round_cnt_d;
  logic [ROUND_W-1:0] round_inc;
  logic               entry_q;  // first cycle after a state change
  logic               wc_load;
  logic               wc_enable;
  logic [CntW-1:0]    wc_load_val;
  logic               wc_tc;
  logic               wd_expired;

  assign round_inc = round_cnt_q + 1'b1;
  assign wc_load   = (state_d != state_q);

`ifdef ACC_ROUND_TIMEOUT_EN
  logic watch_state;
  logic terr_q, terr_d;

  assign watch_state = (state_q == StKey) || (state_q == StIntt) || (state_q == StNtt);
  assign wd_expired  = watch_state & wc_tc;
  assign wc_enable   = (state_q == StDecomp) | watch_state;
  assign wc_load_val = (state_d == StDecomp) ? CntW'(DECOMP_WAIT - 1) : CntW'(TIMEOUT_CYC - 1);

  // Sticky timeout flag: cleared by an accepted start, abort blocks both edits.
  always_comb begin
    terr_d = terr_q;
    if (!abort) begin
      if ((state_q == StIdle) && start) begin
        terr_d = 1'b0;
      end else if (wd_expired) begin
        terr_d = 1'b1;
      end
    end
  end

  // Timeout flag register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      terr_q <= 1'b0;
    end else begin
      terr_q <= terr_d;
    end
  end

  assign timeout_err = terr_q;
`else
  assign wd_expired  = 1'b0;
  assign wc_enable   = (state_q == StDecomp);
  assign wc_load_val = CntW'(DECOMP_WAIT - 1);
  assign timeout_err = 1'b0;
`endif

  // Reloaded on every state change: decompose delay in StDecomp, watchdog elsewhere.
  acc_wait_counter #(
    .WIDTH (CntW)
  ) u_wait_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (wc_load),
    .load_val (wc_load_val),
    .enable   (wc_enable),
    .tc       (wc_tc)
  );

  // Next-state logic; abort overrides every transition and register update.
  always_comb begin
    state_d     = state_q;
    n_lat_d     = n_lat_q;
    round_cnt_d = round_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          n_lat_d     = n_rounds;
          round_cnt_d = '0;
          state_d     = (n_rounds == '0) ? StFin : StKey;
        end
      end
      StKey: begin
        if (key_ack) begin
          state_d = StIntt;
        end else if (wd_expired) begin
          state_d = StIdle;
        end
      end
      StIntt: begin
        if (intt_done) begin
          state_d = StDecomp;
        end else if (wd_expired) begin
          state_d = StIdle;
        end
      end
      StDecomp: begin
        if (wc_tc) begin
          state_d = StNtt;
        end
      end
      StNtt: begin
        if (ntt_done) begin
          state_d = StNext;
        end else if (wd_expired) begin
          state_d = StIdle;
        end
      end
      StNext: begin
        round_cnt_d = round_inc;
        state_d     = (round_inc == n_lat_q) ? StFin : StKey;
      end
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    if (abort) begin
      state_d     = StIdle;
      n_lat_d     = n_lat_q;
      round_cnt_d = round_cnt_q;
    end
  end

  // State, latched round count and progress registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      n_lat_q     <= '0;
      round_cnt_q <= '0;
      entry_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_lat_q     <= n_lat_d;
      round_cnt_q <= round_cnt_d;
      entry_q     <= (state_d != state_q);
    end
  end

  // Outputs decode from registered state only.
  always_comb begin
    busy       = (state_q != StIdle);
    key_req    = (state_q == StKey);
    intt_start = (state_q == StIntt) && entry_q;
    ntt_start  = (state_q == StNtt) && entry_q;
    done_acc   = (state_q == StNtt) && (round_cnt_q == (n_lat_q - 1'b1));
    done       = (state_q == StFin);
    key_idx    = round_cnt_q;
    round_cnt  = round_cnt_q;
  end

endmodule

// File: tb/tb_acc_round_scheduler.sv
// Bench for acc_round_scheduler: table vectors, random runs against a
// cycle-count model, and hand-written abort/reset/timeout sequences.
module tb_acc_round_scheduler;

  localparam int unsigned RW = 10;
  localparam int unsigned DW = 9;
  localparam int unsigned TO = 100;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          abort;
  logic [RW-1:0] n_rounds;
  logic          key_req;
  logic          key_ack;
  logic [RW-1:0] key_idx;
  logic          intt_start;
  logic          intt_done;
  logic          ntt_start;
  logic          ntt_done;
  logic          busy;
  logic          done_acc;
  logic          done;
  logic [RW-1:0] round_cnt;
  logic          timeout_err;

  acc_round_scheduler #(
    .ROUND_W     (RW),
    .DECOMP_WAIT (DW),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .abort       (abort),
    .n_rounds    (n_rounds),
    .key_req     (key_req),
    .key_ack     (key_ack),
    .key_idx     (key_idx),
    .intt_start  (intt_start),
    .intt_done   (intt_done),
    .ntt_start   (ntt_start),
    .ntt_done    (ntt_done),
    .busy        (busy),
    .done_acc    (done_acc),
    .done        (done),
    .round_cnt   (round_cnt),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Measurements from the last run.
  int m_fin, m_acc, m_intt, m_ntt, m_done, m_kreq, m_idx_err, m_busy;
  int m_busy_probe, m_terr_probe, m_cnt_probe;

  typedef struct {
    int n;
    int k;
    int l1;
    int l2;
    bit stray;
    int fin;
    int acc;
  } vec_t;

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Cycle (1 = first cycle after the start edge) in which done is high:
  // each round spends k+1 in KEY, l1+1 in INTT, DW in DECOMP, l2+1 in NTT, 1 in NEXT.
  function automatic int exp_fin(input int n, input int k, input int l1, input int l2);
    return 1 + n * (k + l1 + l2 + int'(DW) + 4);
  endfunction

  task automatic clear_inputs();
    start     = 1'b0;
    abort     = 1'b0;
    key_ack   = 1'b0;
    intt_done = 1'b0;
    ntt_done  = 1'b0;
  endtask

  // Launch one run and play the key/INTT/NTT responders cycle by cycle.
  task automatic run(input int n, input int k, input int l1, input int l2, input bit stray,
                     input int abort_at, input int rst_at, input int probe_at, input int limit);
    int kc;
    int ic;
    int nc;
    int exp_idx;
    bit prev_kreq;
    kc = 0; ic = -1; nc = -1; exp_idx = 0; prev_kreq = 1'b0;
    m_fin = -1; m_acc = 0; m_intt = 0; m_ntt = 0; m_done = 0; m_kreq = 0;
    m_idx_err = 0; m_busy = 0; m_busy_probe = -1; m_terr_probe = -1; m_cnt_probe = -1;
    @(negedge clk);
    n_rounds = RW'(n);
    start    = 1'b1;
    for (int cyc = 1; cyc <= limit; cyc++) begin
      @(negedge clk);
      clear_inputs();
      if (cyc == rst_at) begin
        reset = 1'b1;
        #1;
        check("reset_async_flags",
              {key_req, intt_start, ntt_start, done_acc, done, busy, timeout_err}, 0);
        check("reset_async_round_cnt", round_cnt, 0);
        check("reset_async_key_idx", key_idx, 0);
        break;
      end
      if (cyc == probe_at) begin
        m_busy_probe = busy;
        m_terr_probe = timeout_err;
        m_cnt_probe  = round_cnt;
      end
      if (busy) m_busy++;
      if (intt_start) m_intt++;
      if (ntt_start) m_ntt++;
      if (done_acc) m_acc++;
      if (key_req && !prev_kreq) begin
        m_kreq++;
        if (key_idx != RW'(exp_idx)) m_idx_err++;
        exp_idx++;
      end
      prev_kreq = key_req;
      if (done) begin
        m_done++;
        if (m_fin < 0) m_fin = cyc;
      end
      if (key_req) begin
        key_ack = (kc == k);
        kc++;
      end else begin
        kc = 0;
      end
      if (intt_start) ic = 0;
      else if (ic >= 0) ic++;
      if (ic >= 0 && ic == l1) begin
        intt_done = 1'b1;
        ic = -1;
      end
      if (ntt_start) nc = 0;
      else if (nc >= 0) nc++;
      if (nc >= 0 && nc == l2) begin
        ntt_done = 1'b1;
        nc = -1;
      end
      if (stray) begin
        if (key_req) begin
          intt_done = 1'b1;
          ntt_done  = 1'b1;
        end else if (busy) begin
          key_ack = 1'b1;
        end
        if (busy && $urandom_range(0, 3) == 0) start = 1'b1;
        if (busy) n_rounds = RW'($urandom);
      end
      if (cyc == abort_at) abort = 1'b1;
      if (done && abort_at == 0) break;
    end
    clear_inputs();
  endtask

  // Full set of checks for a run that must complete normally.
  task automatic check_run(input string tag, input int n, input int fin, input int acc);
    check({tag, "_fin_cycle"}, m_fin, fin);
    check({tag, "_done_cnt"}, m_done, 1);
    check({tag, "_busy_cycles"}, m_busy, fin);
    check({tag, "_intt_starts"}, m_intt, n);
    check({tag, "_ntt_starts"}, m_ntt, n);
    check({tag, "_key_reqs"}, m_kreq, n);
    check({tag, "_key_idx_errs"}, m_idx_err, 0);
    check({tag, "_done_acc_cycles"}, m_acc, acc);
    check({tag, "_round_cnt"}, round_cnt, n);
    @(negedge clk);
    check({tag, "_idle_after"}, {busy, done}, 0);
  endtask

  initial begin
    vec_t tbl[5];
    tbl[0] = '{n: 3,    k: 2, l1: 20, l2: 20, stray: 1'b0, fin: 166,   acc: 21};
    tbl[1] = '{n: 0,    k: 0, l1: 0,  l2: 0,  stray: 1'b0, fin: 1,     acc: 0};
    tbl[2] = '{n: 1,    k: 0, l1: 0,  l2: 0,  stray: 1'b0, fin: 14,    acc: 1};
    tbl[3] = '{n: 2,    k: 1, l1: 3,  l2: 5,  stray: 1'b1, fin: 45,    acc: 6};
    tbl[4] = '{n: 1023, k: 0, l1: 0,  l2: 0,  stray: 1'b0, fin: 13300, acc: 1};

    reset    = 1'b1;
    n_rounds = '0;
    clear_inputs();
    repeat (2) @(negedge clk);
    check("reset_flags", {key_req, intt_start, ntt_start, done_acc, done, busy, timeout_err}, 0);
    check("reset_round_cnt", round_cnt, 0);
    check("reset_key_idx", key_idx, 0);
    reset = 1'b0;

    // Abort wins over a simultaneous start in IDLE.
    @(negedge clk);
    n_rounds = RW'(1);
    start    = 1'b1;
    abort    = 1'b1;
    @(negedge clk);
    clear_inputs();
    check("abort_beats_start", busy, 0);

    for (int i = 0; i < 5; i++) begin
      run(tbl[i].n, tbl[i].k, tbl[i].l1, tbl[i].l2, tbl[i].stray, 0, 0, 0, tbl[i].fin + 20);
      check_run($sformatf("vec%0d", i), tbl[i].n, tbl[i].fin, tbl[i].acc);
    end

    for (int i = 0; i < 8; i++) begin
      int n, k, l1, l2, fin;
      bit stray;
      n     = int'($urandom_range(0, 4));
      k     = int'($urandom_range(0, 3));
      l1    = int'($urandom_range(0, 4));
      l2    = int'($urandom_range(0, 4));
      stray = 1'($urandom_range(0, 1));
      fin   = exp_fin(n, k, l1, l2);
      run(n, k, l1, l2, stray, 0, 0, 0, fin + 20);
      check_run($sformatf("rand%0d", i), n, fin, (n > 0) ? l2 + 1 : 0);
    end

    // Abort in the second DECOMP (cycles 16..24 with zero latencies).
    run(2, 0, 0, 0, 1'b0, 18, 0, 19, 40);
    check("abort_busy_next", m_busy_probe, 0);
    check("abort_round_cnt_next", m_cnt_probe, 1);
    check("abort_no_done", m_done, 0);
    check("abort_ntt_starts", m_ntt, 1);
    check("abort_round_cnt_end", round_cnt, 1);

    // Reset in round 1 NTT (cycles 12..17) of a 4-round run, then a fresh 1-round run.
    run(4, 0, 0, 5, 1'b0, 0, 14, 0, 40);
    check("rst_run_no_done", m_done, 0);
    check("rst_run_ntt_starts", m_ntt, 1);
    repeat (2) @(negedge clk);
    check("rst_held_idle", {busy, done, key_req}, 0);
    reset = 1'b0;
    run(1, 0, 0, 0, 1'b0, 0, 0, 0, 40);
    check_run("after_rst", 1, 14, 1);

`ifdef ACC_ROUND_TIMEOUT_EN
    // INTT occupies cycles 2..101; the watchdog returns to IDLE in cycle 102.
    run(1, 0, 1000000, 0, 1'b0, 0, 0, 101, 101);
    check("to_not_yet", m_terr_probe, 0);
    check("to_busy_before", m_busy_probe, 1);
    @(negedge clk);
    check("to_err_set", timeout_err, 1);
    check("to_idle", busy, 0);
    check("to_no_done", m_done, 0);
    run(0, 0, 0, 0, 1'b0, 0, 0, 1, 20);
    check("to_cleared_by_start", m_terr_probe, 0);
`else
    check("no_watchdog_err", timeout_err, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
